// File: rtl/mod_delay_pkg.sv
// Shared constants and FSM encoding for the modulated delay tap.
package mod_delay_pkg;

  localparam int FRAC_WIDTH = 8;
  localparam int WEIGHT_ONE = 256;
  localparam int TRI_WIDTH  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_A   = 3'd1,
    ST_RD_B   = 3'd2,
    ST_RD_DRY = 3'd3,
    ST_CALC   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/mod_delay_if.sv
// smart_ram read channel: the delay block is the master, the memory the slave.
interface mod_delay_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13
);
  logic                  sram_rd;
  logic [ADDR_WIDTH-1:0] sram_offset;
  logic                  sram_read_finish;
  logic [DATA_WIDTH-1:0] sram_data_in;

  modport master (output sram_rd, sram_offset, input sram_read_finish, sram_data_in);
  modport slave  (input sram_rd, sram_offset, output sram_read_finish, sram_data_in);
endinterface

// File: rtl/mod_delay_lfo.sv
// Phase accumulator plus triangle shaper driving the delay modulation.
module mod_delay_lfo
  import mod_delay_pkg::*;
#(
  parameter int PHASE_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   advance,
  input  logic [PHASE_WIDTH-1:0] rate_inc,
  output logic [TRI_WIDTH-1:0]   tri_out
);

  logic [PHASE_WIDTH-1:0] phase_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) phase_q <= '0;
    else if (advance) phase_q <= phase_q + rate_inc;
  end

  // Upper half of the cycle folds back down by inverting the ramp.
  assign tri_out = phase_q[PHASE_WIDTH-1] ? ~phase_q[PHASE_WIDTH-2 -: TRI_WIDTH]
                                          :  phase_q[PHASE_WIDTH-2 -: TRI_WIDTH];

endmodule

// File: rtl/mod_delay.sv
// Modulated delay tap with linear interpolation between two stored samples.
// Optional wet/dry mix stage enabled by defining MOD_DELAY_MIX_EN.
//
// state  | meaning
// IDLE   | wait for cs & my_turn, latch integer/fractional delay
// RD_A   | read sample at delay n
// RD_B   | read sample at delay n+1
// RD_DRY | read current (undelayed) sample, mix builds only
// CALC   | interpolate (and mix), register data_out
// DONE   | one-cycle done strobe, advance LFO phase
module mod_delay
  import mod_delay_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int ADDR_WIDTH       = 13,
  parameter int PHASE_WIDTH      = 24,
  parameter int BASE_DELAY       = 48,
  parameter int WORDS_PER_SAMPLE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cs,
  input  logic                   my_turn,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  data_out,
  input  logic [PHASE_WIDTH-1:0] rate_inc,
  input  logic [7:0]             depth,
  mod_delay_if.master            sram
`ifdef MOD_DELAY_MIX_EN
  , input logic [7:0]            mix
`endif
);

  localparam int ACC_W = DATA_WIDTH + 11;

  state_t state_q, state_d;
  logic                         first_q;
  logic [31-FRAC_WIDTH:0]       n_q;
  logic [FRAC_WIDTH-1:0]        f_q;
  logic signed [DATA_WIDTH-1:0] a_q, b_q, data_out_q;
  logic [TRI_WIDTH-1:0]         tri_w;
  logic [31:0]                  d_w;
  logic [ADDR_WIDTH-1:0]        off_a_w, off_b_w, offset_w;
  logic                         rd_w, rd_ack_w, advance_w;

  mod_delay_lfo #(.PHASE_WIDTH(PHASE_WIDTH)) u_lfo (
    .clk      (clk),
    .rst      (rst),
    .advance  (advance_w),
    .rate_inc (rate_inc),
    .tri_out  (tri_w)
  );

  assign d_w     = 32'(BASE_DELAY * WEIGHT_ONE) + ((32'(depth) * 32'(tri_w)) >> FRAC_WIDTH);
  assign off_a_w = ADDR_WIDTH'(32'(n_q) * 32'(WORDS_PER_SAMPLE));
  assign off_b_w = ADDR_WIDTH'((32'(n_q) + 32'd1) * 32'(WORDS_PER_SAMPLE));
  // The request cycle itself never accepts a finish; only later cycles do.
  assign rd_ack_w = !first_q && sram.sram_read_finish;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    rd_w      = 1'b0;
    offset_w  = '0;
    done      = 1'b0;
    advance_w = 1'b0;
    case (state_q)
      ST_IDLE: if (cs && my_turn) state_d = ST_RD_A;
      ST_RD_A: begin
        rd_w     = first_q;
        offset_w = off_a_w;
        if (rd_ack_w) state_d = ST_RD_B;
      end
      ST_RD_B: begin
        rd_w     = first_q;
        offset_w = off_b_w;
`ifdef MOD_DELAY_MIX_EN
        if (rd_ack_w) state_d = ST_RD_DRY;
`else
        if (rd_ack_w) state_d = ST_CALC;
`endif
      end
`ifdef MOD_DELAY_MIX_EN
      ST_RD_DRY: begin
        rd_w = first_q;
        if (rd_ack_w) state_d = ST_CALC;
      end
`endif
      ST_CALC: state_d = ST_DONE;
      ST_DONE: begin
        done      = 1'b1;
        advance_w = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sram.sram_rd     = rd_w;
  assign sram.sram_offset = offset_w;

  logic signed [9:0]         w_a, w_b;
  logic signed [ACC_W-1:0]   acc_w;
  logic signed [DATA_WIDTH-1:0] wet_w, result_w;

  assign w_b   = $signed({2'b00, f_q});
  assign w_a   = $signed(10'(WEIGHT_ONE)) - w_b;
  assign acc_w = ACC_W'(a_q) * ACC_W'(w_a) + ACC_W'(b_q) * ACC_W'(w_b);
  assign wet_w = DATA_WIDTH'(acc_w >>> FRAC_WIDTH);

`ifdef MOD_DELAY_MIX_EN
  logic signed [DATA_WIDTH-1:0] dry_q;
  logic signed [9:0]            wm_a, wm_b;
  logic signed [ACC_W-1:0]      mix_acc_w;

  assign wm_b      = $signed({2'b00, mix});
  assign wm_a      = $signed(10'(WEIGHT_ONE)) - wm_b;
  assign mix_acc_w = ACC_W'(dry_q) * ACC_W'(wm_a) + ACC_W'(wet_w) * ACC_W'(wm_b);
  assign result_w  = DATA_WIDTH'(mix_acc_w >>> FRAC_WIDTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dry_q <= '0;
    else if (state_q == ST_RD_DRY && rd_ack_w) dry_q <= $signed(sram.sram_data_in);
  end
`else
  assign result_w = wet_w;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_q    <= 1'b0;
      n_q        <= '0;
      f_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      data_out_q <= '0;
    end else begin
      first_q <= (state_d != state_q);
      if (state_q == ST_IDLE && cs && my_turn) begin
        n_q <= d_w[31:FRAC_WIDTH];
        f_q <= d_w[FRAC_WIDTH-1:0];
      end
      if (state_q == ST_RD_A && rd_ack_w) a_q <= $signed(sram.sram_data_in);
      if (state_q == ST_RD_B && rd_ack_w) b_q <= $signed(sram.sram_data_in);
      if (state_q == ST_CALC) data_out_q <= result_w;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_mod_delay.sv
// Directed table-driven bench for mod_delay with a scripted smart_ram responder.
module tb_mod_delay;

  localparam int DW = 16;
  localparam int AW = 13;
  localparam int PW = 24;
`ifdef MOD_DELAY_MIX_EN
  localparam int NREADS = 3;
  localparam int DRY    = 400;
  localparam int MIXV   = 64;
`else
  localparam int NREADS = 2;
  localparam int DRY    = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cs = 1'b0, my_turn = 1'b0;
  logic          done;
  logic [DW-1:0] data_out;
  logic [PW-1:0] rate_inc = '0;
  logic [7:0]    depth = '0;
`ifdef MOD_DELAY_MIX_EN
  logic [7:0]    mix = 8'(MIXV);
`endif

  mod_delay_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mod_delay dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .my_turn  (my_turn),
    .done     (done),
    .data_out (data_out),
    .rate_inc (rate_inc),
    .depth    (depth),
    .sram     (bus)
`ifdef MOD_DELAY_MIX_EN
    , .mix    (mix)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rd_count = 0;
  int prev_out = 0;

  always @(negedge clk) if (bus.sram_rd) rd_count <= rd_count + 1;

  typedef struct {
    logic [PW-1:0] rate;
    logic [7:0]    depth;
    int a;
    int b;
    int off_a;
    int off_b;
    int wet;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int final_out(input int wet);
`ifdef MOD_DELAY_MIX_EN
    return (DRY * (256 - MIXV) + wet * MIXV) >>> 8;
`else
    return wet;
`endif
  endfunction

  task automatic wait_rd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.sram_rd) begin ok = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  task automatic run_sample(input vec_t v, input string tag);
    int dat[3];
    int offs;
    int rd_before;
    int exp;
    bit ok;
    dat[0] = v.a; dat[1] = v.b; dat[2] = DRY;
    exp = final_out(v.wet);
    rate_inc = v.rate; depth = v.depth; cs = 1'b1; my_turn = 1'b1;
    rd_before = rd_count;
    for (int k = 0; k < NREADS; k++) begin
      wait_rd(ok);
      if (!ok) begin check({tag, " rd_timeout"}, 0, 1); cs = 1'b0; my_turn = 1'b0; return; end
      offs = int'(bus.sram_offset);
      if (k == 0) begin
        check({tag, " off_a"}, offs, v.off_a);
        check({tag, " hold"}, int'($signed(data_out)), prev_out);
        cs = 1'b0; my_turn = 1'b0;
      end else if (k == 1) check({tag, " off_b"}, offs, v.off_b);
      else check({tag, " off_dry"}, offs, 0);
      @(negedge clk);
      check({tag, " off_stable"}, int'(bus.sram_offset), offs);
      bus.sram_read_finish = 1'b1;
      bus.sram_data_in = DW'(dat[k]);
      @(negedge clk);
      bus.sram_read_finish = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (done) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin check({tag, " done_timeout"}, 0, 1); return; end
    check({tag, " data_out"}, int'($signed(data_out)), exp);
    @(negedge clk);
    check({tag, " done_width"}, int'(done), 0);
    check({tag, " rd_pulses"}, rd_count - rd_before, NREADS);
    prev_out = exp;
  endtask

  vec_t tbl[8];
  bit   ok_r;
  int   rd_snap;

  initial begin
    bus.sram_read_finish = 1'b0;
    bus.sram_data_in = '0;

    //         rate       depth  A       B      offA  offB  wet
    tbl[0] = '{24'h000000, 8'd0,   1000,   3000,  192,  196, 1000};
    tbl[1] = '{24'h400000, 8'd3,   100,    200,   192,  196, 100};
    tbl[2] = '{24'h000000, 8'd3,   100,    200,   196,  200, 150};
    tbl[3] = '{24'h000000, 8'd3,   -32768, 32767, 196,  200, -1};
    tbl[4] = '{24'h400000, 8'd0,   -5,     7,     192,  196, -5};
    tbl[5] = '{24'h800000, 8'd255, 256,    512,   1208, 1212, 511};
    tbl[6] = '{24'h200000, 8'd255, -100,   50,    192,  196, -100};
    tbl[7] = '{24'h200000, 8'd255, -3,     0,     444,  448, -1};

    #1;
    check("rst sram_rd", int'(bus.sram_rd), 0);
    check("rst offset", int'(bus.sram_offset), 0);
    check("rst done", int'(done), 0);
    check("rst data_out", int'(data_out), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_sample(tbl[i], $sformatf("vec%0d", i));

    // Phase is now 0x400000: depth 3 starts at n=49, then reset lands mid RD_B.
    depth = 8'd3; rate_inc = '0; cs = 1'b1; my_turn = 1'b1;
    wait_rd(ok_r);
    check("rstseq rd_a seen", int'(ok_r), 1);
    check("rstseq off_a", int'(bus.sram_offset), 196);
    cs = 1'b0; my_turn = 1'b0;
    @(negedge clk);
    bus.sram_read_finish = 1'b1; bus.sram_data_in = 16'd7;
    @(negedge clk);
    bus.sram_read_finish = 1'b0;
    wait_rd(ok_r);
    check("rstseq rd_b seen", int'(ok_r), 1);
    check("rstseq off_b", int'(bus.sram_offset), 200);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstseq sram_rd", int'(bus.sram_rd), 0);
    check("rstseq offset", int'(bus.sram_offset), 0);
    check("rstseq done", int'(done), 0);
    check("rstseq data_out", int'(data_out), 0);
    @(negedge clk);
    rst = 1'b1;
    bus.sram_read_finish = 1'b1; bus.sram_data_in = 16'd9;
    rd_snap = rd_count;
    @(negedge clk);
    bus.sram_read_finish = 1'b0;
    repeat (4) @(negedge clk);
    check("rstseq late_finish rd", rd_count - rd_snap, 0);
    check("rstseq late_finish done", int'(done), 0);
    prev_out = 0;
    run_sample('{24'h000000, 8'd3, 1000, 3000, 192, 196, 1000}, "post_rst");

`ifdef MOD_DELAY_MIX_EN
    run_sample('{24'h000000, 8'd0, 800, 123, 192, 196, 800}, "mix64");
    check("mix64 value", prev_out, 500);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
